// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper.
// Optional build macro: SWEEP_GRAY_ORDER_EN selects Gray-code drive order.
package truth_table_sweeper_pkg;

  localparam int unsigned NUM_VECTORS = 8;
  localparam int unsigned VEC_W       = 3;
  localparam int unsigned CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Captured sweep result held between sweeps
  typedef struct packed {
    logic [NUM_VECTORS-1:0] tbl;
    logic                   mismatch;
    logic [VEC_W-1:0]       fail_idx;
  } sweep_result_t;

  // Maps the sequence position to the {A,B,C} vector driven at that position
  function automatic logic [VEC_W-1:0] vector_of(input logic [VEC_W-1:0] seq);
`ifdef SWEEP_GRAY_ORDER_EN
    return seq ^ (seq >> 1);
`else
    return seq;
`endif
  endfunction

endpackage

// File: rtl/truth_table_sweeper_first_diff.sv
// Lowest-set-bit encoder: index of the first differing truth-table entry.
module tts_first_diff
  import truth_table_sweeper_pkg::*;
(
  input  logic [NUM_VECTORS-1:0] i_bits,
  output logic [VEC_W-1:0]       o_idx_c,
  output logic                   o_any_c
);

  // Scan from the top so the lowest set bit is the last (winning) assignment
  always_comb begin
    o_idx_c = '0;
    o_any_c = 1'b0;
    for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
      if (i_bits[i]) begin
        o_idx_c = VEC_W'(i);
        o_any_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all eight {A,B,C} vectors through a 3-input logic block, captures f
// into a truth table and compares it against EXPECTED.
// Optional build macro: SWEEP_GRAY_ORDER_EN (Gray-code drive order; results
// and latency are unchanged).
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned            SETTLE_CYCLES = 4,
  parameter logic [NUM_VECTORS-1:0] EXPECTED      = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   f,
  output logic                   A,
  output logic                   B,
  output logic                   C,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_VECTORS-1:0] table_out,
  output logic                   mismatch,
  output logic [VEC_W-1:0]       fail_idx
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] SEQ_LAST = VEC_W'(NUM_VECTORS - 1);

  state_t                 r_state, w_state_nxt;
  logic [VEC_W-1:0]       r_seq, w_seq_nxt;
  logic [VEC_W-1:0]       r_vec, w_vec_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
  sweep_result_t          r_res, w_res_nxt;

  logic [NUM_VECTORS-1:0] w_tbl_upd;
  logic [VEC_W-1:0]       w_first_idx;
  logic                   w_any_diff;

  // Table as it will look once the current f sample is written in
  always_comb begin
    w_tbl_upd        = r_res.tbl;
    w_tbl_upd[r_vec] = f;
  end

  tts_first_diff u_first_diff (
    .i_bits  (w_tbl_upd ^ EXPECTED),
    .o_idx_c (w_first_idx),
    .o_any_c (w_any_diff)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_seq   <= '0;
      r_vec   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_seq   <= w_seq_nxt;
      r_vec   <= w_vec_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_res   <= w_res_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_seq_nxt   = r_seq;
    w_vec_nxt   = r_vec;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_res_nxt   = r_res;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_res_nxt   = '0;
          w_seq_nxt   = '0;
          w_vec_nxt   = vector_of(VEC_W'(0));
          w_cnt_nxt   = CNT_LOAD;
          w_busy_nxt  = 1'b1;
          w_state_nxt = SETTLE;
        end
      end

      SETTLE: begin
        if (abort) begin
          w_state_nxt = IDLE;
          w_seq_nxt   = '0;
          w_vec_nxt   = '0;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end else if (r_cnt == '0) begin
          w_state_nxt = SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      SAMPLE: begin
        if (abort) begin
          w_state_nxt = IDLE;
          w_seq_nxt   = '0;
          w_vec_nxt   = '0;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end else begin
          w_res_nxt.tbl = w_tbl_upd;
          if (r_seq == SEQ_LAST) begin
            // Comparison result is registered alongside the done pulse
            w_res_nxt.mismatch = w_any_diff;
            w_res_nxt.fail_idx = w_first_idx;
            w_done_nxt         = 1'b1;
            w_vec_nxt          = '0;
            w_seq_nxt          = '0;
            w_state_nxt        = DONE;
          end else begin
            w_seq_nxt   = r_seq + VEC_W'(1);
            w_vec_nxt   = vector_of(r_seq + VEC_W'(1));
            w_cnt_nxt   = CNT_LOAD;
            w_state_nxt = SETTLE;
          end
        end
      end

      DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Register-to-port mapping
  assign A         = r_vec[2];
  assign B         = r_vec[1];
  assign C         = r_vec[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign table_out = r_res.tbl;
  assign mismatch  = r_res.mismatch;
  assign fail_idx  = r_res.fail_idx;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper (SETTLE_CYCLES=4, EXPECTED=8'h96).
// Optional build macro: SWEEP_GRAY_ORDER_EN changes the expected drive order.
module tb_truth_table_sweeper;

  localparam int unsigned SC  = 4;
  localparam int unsigned WIN = SC + 1;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, mode;
  logic       f;
  logic       A, B, C, busy, done, mismatch;
  logic [7:0] table_out;
  logic [2:0] fail_idx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] tbl;
    logic       mis;
    logic [2:0] idx;
    int         at;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] ord[8];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Logic block under test: mode 0 = 3-input XOR, mode 1 = majority
  assign f = mode ? ((A & B) | (A & C) | (B & C)) : (A ^ B ^ C);

  truth_table_sweeper #(
    .SETTLE_CYCLES (SC),
    .EXPECTED      (8'h96)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .f         (f),
    .A         (A),
    .B         (B),
    .C         (C),
    .busy      (busy),
    .done      (done),
    .table_out (table_out),
    .mismatch  (mismatch),
    .fail_idx  (fail_idx)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_abc"},      32'({A, B, C}), 0);
    chk({tag, "_busy"},     32'(busy), 0);
    chk({tag, "_done"},     32'(done), 0);
    chk({tag, "_table"},    32'(table_out), 0);
    chk({tag, "_mismatch"}, 32'(mismatch), 0);
    chk({tag, "_fail_idx"}, 32'(fail_idx), 0);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d want no pulse", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle",   32'(cyc), 32'(e.at));
        chk("table_out",    32'(table_out), 32'(e.tbl));
        chk("mismatch",     32'(mismatch), 32'(e.mis));
        chk("fail_idx",     32'(fail_idx), 32'(e.idx));
        chk("busy_at_done", 32'(busy), 1);
      end
    end
  end

  // One full sweep started at a negedge; optionally pokes start mid-sweep
  task automatic sweep(input logic m, input logic [7:0] et, input logic em,
                       input logic [2:0] ei, input bit poke);
    int nb;
    mode  = m;
    start = 1'b1;
    sb.push_back('{et, em, ei, cyc + 41});
    nb = 0;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (j == 0) start = 1'b0;
      if (poke && j == 10) start = 1'b1;
      if (poke && j == 11) start = 1'b0;
      if (busy) nb++;
      if (j < 8 * WIN && (j % WIN) == 2) chk("vector", 32'({A, B, C}), 32'(ord[j / WIN]));
      if (!busy) break;
    end
    chk("busy_cycles", 32'(nb), 41);
    chk("sb_drained", 32'(sb.size()), 0);
  endtask

  initial begin
    int         k0;
    logic [7:0] pt;
`ifdef SWEEP_GRAY_ORDER_EN
    ord = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
`else
    ord = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode  = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // XOR block matches EXPECTED
    sweep(1'b0, 8'h96, 1'b0, 3'd0, 1'b0);
    // Majority block: 8'hE8 vs 8'h96 differs first at bit 1; start poked while busy
    sweep(1'b1, 8'hE8, 1'b1, 3'd1, 1'b1);

    // Abort while vector 3 is held
    mode  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    chk("abort_vec_before", 32'({A, B, C}), 32'(ord[3]));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    pt = 8'h00;
    for (int k = 0; k < 3; k++) pt[ord[k]] = ^ord[k];
    chk("abort_busy",     32'(busy), 0);
    chk("abort_abc",      32'({A, B, C}), 0);
    chk("abort_mismatch", 32'(mismatch), 0);
    chk("abort_table",    32'(table_out), 32'(pt));
    repeat (5) @(negedge clk);
    chk("abort_idle", 32'(busy), 0);

    // start and abort together in IDLE: start wins
    start = 1'b1;
    abort = 1'b1;
    sb.push_back('{8'h96, 1'b0, 3'd0, cyc + 41});
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_wins", 32'(busy), 1);
    repeat (45) @(negedge clk);
    chk("sb_drained_sa", 32'(sb.size()), 0);

    // start held high: back-to-back sweeps with one IDLE cycle between
    k0    = cyc;
    start = 1'b1;
    sb.push_back('{8'h96, 1'b0, 3'd0, k0 + 41});
    sb.push_back('{8'h96, 1'b0, 3'd0, k0 + 83});
    repeat (42) @(negedge clk);
    chk("held_gap_busy", 32'(busy), 0);
    @(negedge clk);
    chk("held_restart_busy", 32'(busy), 1);
    start = 1'b0;
    repeat (45) @(negedge clk);
    chk("sb_drained_held", 32'(sb.size()), 0);

    // Asynchronous reset in the middle of a sweep
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("pre_reset_busy",  32'(busy), 1);
    chk("pre_reset_table", 32'(table_out), 8'h02);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sweep(1'b0, 8'h96, 1'b0, 3'd0, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound on the whole run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at cycle %0d want completion", cyc);
    $fatal(1);
  end

endmodule
